fetch_replay_buffer: RTL
========================

Name: fetch_replay_buffer

Overview:
- 4-way instruction queue between the IF stage and the ID stage.
- Accepts up to WAYS fetched instructions per cycle and presents the oldest WAYS entries to ID.
- Consumes the ID-stage hazard rollback count, so the trailing rolled-back ways stay in the queue and are re-presented next cycle.
- Flushed by branch squash.

Parameters:
- WAYS, 4, superscalar width; in/out lanes per cycle.
- DEPTH, 16, entry count; power of two, must be >= 2*WAYS.
- ROLLBACK_WIDTH, 3, width of the rollback input; encodes 0..WAYS.
- XLEN, 32, width of the PC and instruction fields.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears the queue.
- in_valid  input  WAYS  per-lane fetch valid; lane 0 is the oldest.
- in_pc  input  WAYS*XLEN  PC per lane, lane i at bits [i*XLEN +: XLEN].
- in_inst  input  WAYS*XLEN  instruction word per lane.
- in_ready  output  1  queue can accept a full WAYS-wide group this cycle.
- out_valid  output  WAYS  lane i holds the (i+1)-th oldest entry.
- out_pc  output  WAYS*XLEN  PCs of the head entries.
- out_inst  output  WAYS*XLEN  instruction words of the head entries.
- rollback  input  ROLLBACK_WIDTH  number of trailing presented lanes ID did not accept this cycle (combinational from the detection unit).
- stall  input  1  downstream stall; nothing is consumed.
- squash  input  1  mispredict flush; empties the queue.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- **State:** head_ptr and tail_ptr, each $clog2(DEPTH) bits, wrapping mod DEPTH; count register; storage array of DEPTH entries of {pc, inst}. No reset of array contents is required.
- **Reset and squash:** both take effect at the next edge.
  - reset: head_ptr=0, tail_ptr=0, count=0.
  - squash: same result; any same-cycle push and pop are discarded.
  - reset takes priority over squash.
- **Reset output values:** out_valid=0, count=0, in_ready=1. out_pc/out_inst are don't-care while their lane is invalid.
- **Presentation (combinational from registered state):**
  - out_valid[i] = (i < count).
  - out_pc/out_inst lane i = array[(head_ptr+i) mod DEPTH].
  - Wrap-around across the array end must be seamless.
- **Accept count:** n_in = length of the contiguous run of 1s in in_valid starting at lane 0. Lanes after the first 0 are ignored. Example: in_valid=4'b1011 gives n_in=2.
- **Push enable:** push occurs only when in_ready=1. in_ready = (DEPTH - count >= WAYS), computed from registered count only; it does not credit a same-cycle pop. When in_ready=0, input lanes are dropped and the fetch stage must hold them.
- **Consume count:** presented = min(count, WAYS).
  - n_out = 0 if stall = 1.
  - Otherwise n_out = presented - rollback, clamped at 0 when rollback > presented.
  - rollback values greater than WAYS are treated as WAYS.
- **Update at the edge:**
  - Entries from accepted lanes 0..n_in-1 are written to array[(tail_ptr+i) mod DEPTH].
  - tail_ptr += n_in; head_ptr += n_out; count = count + n_in - n_out.
- **Simultaneous events:**
  - Push and pop in the same cycle are legal and independent.
  - A pushed entry is never presented in the cycle it arrives; the minimum IF-to-ID latency is 1 cycle.
  - Empty queue with rollback or stall asserted: no effect.
  - A full queue (count=DEPTH) still pops normally.
- **Ordering:** program order is preserved. Rolled-back lanes re-appear at lane 0 upward in the next cycle, with identical pc/inst.
- **Invariants:** count never exceeds DEPTH and never underflows. The implementation asserts both in simulation.

Test Plan:
- **Fill and drain:** after reset, push 4 groups of in_valid=4'b1111 with stall=1 → count=16 and in_ready=0. Release stall with rollback=0 → 4 entries consumed per cycle; PCs appear in order 0x0,0x4,...; count reaches 0 after 4 cycles.
- **Rollback replay:** queue holds PCs 0x100–0x11C; rollback=3 for one cycle → only 0x100 is consumed. Next cycle lanes 0–3 show 0x104,0x108,0x10C,0x110.
- **Partial valid and clamp:** in_valid=4'b1011 → count += 2 only. With count=2, rollback=4 → n_out=0 and count stays 2.
- **Wrap-around:** advance the pointers to head=14, then push 4 and pop 4 every cycle for 10 cycles → continuous PC sequence across the index 15→0 boundary, with no duplicates or gaps.
- **Squash and reset:** with count=9, assert squash together with in_valid=4'b1111 → next cycle count=0, out_valid=0. Repeat with reset mid-fill → same result, and in_ready=1.
- **Ready boundary:** count=12 → in_ready=1 and a push of 4 gives count=16. count=13 with a simultaneous pop of 4 → in_ready=0, the group is dropped, and count=9.

Source files
------------

// File: rtl/fetch_replay_buffer_if.sv
// IF/ID handshake bundle for the fetch replay buffer; master = fetch/decode side, slave = queue.
interface fetch_replay_buffer_if #(
    parameter int WAYS           = 4,
    parameter int DEPTH          = 16,
    parameter int ROLLBACK_WIDTH = 3,
    parameter int XLEN           = 32
);
    logic [WAYS-1:0]           in_valid;
    logic [WAYS*XLEN-1:0]      in_pc;
    logic [WAYS*XLEN-1:0]      in_inst;
    logic                      in_ready;
    logic [WAYS-1:0]           out_valid;
    logic [WAYS*XLEN-1:0]      out_pc;
    logic [WAYS*XLEN-1:0]      out_inst;
    logic [ROLLBACK_WIDTH-1:0] rollback;
    logic                      stall;
    logic                      squash;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output in_valid, in_pc, in_inst, rollback, stall, squash,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, rollback, stall, squash,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_replay_buffer.sv
// WAYS-wide IF->ID instruction queue with ID rollback replay; pushed entries visible after 1 cycle.
// Backpressure: in_ready drops unless a full group fits; rolled-back lanes stay at the head.
module fetch_replay_buffer #(
    parameter int WAYS           = 4,
    parameter int DEPTH          = 16,
    parameter int ROLLBACK_WIDTH = 3,
    parameter int XLEN           = 32
) (
    input logic                  clock,
    input logic                  reset,
    fetch_replay_buffer_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int RBW = ROLLBACK_WIDTH;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          in_ready;
    logic [CW-1:0] n_in;
    logic [CW-1:0] n_push;
    logic [CW-1:0] n_out;
    logic [CW-1:0] presented;
    logic [RBW-1:0] rb_lim;
    logic [CW-1:0] rb;
    logic          run;

    logic [WAYS-1:0]      out_valid;
    logic [WAYS*XLEN-1:0] out_pc;
    logic [WAYS*XLEN-1:0] out_inst;

    // Only credits entries already held; a same-cycle pop does not make room.
    assign in_ready = (count_q <= CW'(DEPTH - WAYS));

    always_comb begin
        n_in = '0;
        run  = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (run && bus.in_valid[i]) begin
                n_in = n_in + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign n_push = in_ready ? n_in : '0;

    always_comb begin
        presented = (count_q < CW'(WAYS)) ? count_q : CW'(WAYS);
        rb_lim    = (bus.rollback > RBW'(WAYS)) ? RBW'(WAYS) : bus.rollback;
        rb        = CW'(rb_lim);
        if (bus.stall || (rb >= presented)) begin
            n_out = '0;
        end else begin
            n_out = presented - rb;
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < WAYS; i++) begin
            if (CW'(i) < n_push) begin
                mem_d[tail_q + PW'(i)].pc   = bus.in_pc[i*XLEN +: XLEN];
                mem_d[tail_q + PW'(i)].inst = bus.in_inst[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(n_out);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + n_push - n_out;
        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale slots are never presented because out_valid tracks count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_inst  = '0;
        for (int i = 0; i < WAYS; i++) begin
            out_valid[i]              = (CW'(i) < count_q);
            out_pc[i*XLEN +: XLEN]    = mem_q[head_q + PW'(i)].pc;
            out_inst[i*XLEN +: XLEN]  = mem_q[head_q + PW'(i)].inst;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_pc;
    assign bus.out_inst  = out_inst;
    assign bus.count     = count_q;

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        count_q <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        n_out <= count_q);
endmodule
